nrzi_decode_ap: RTL and testbench
=================================

NRZI_DECODE_AP -- requirements
Module: nrzi_decode_ap

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 gclk  input  1  clock; all state changes on rising edge.
REQ-003 reset_l  input  1  asynchronous, active-low reset.
REQ-004 start_rxd  input  1  receive enable; 1 = decode, 0 = idle/flush.
REQ-005 rx_data_in  input  1  NRZI line sample, one per gclk.
REQ-006 idle_or_sync, pid, dev_address, end_point_address, crc5, frame_number, data_crc_eop, eop, error  input  1 each  packet-phase flags from the upstream receive FSM.
REQ-007 rx_data_out  output  1  decoded NRZ bit.
REQ-008 rx_data_valid  output  1  rx_data_out holds a real (non-stuffed) bit this cycle.
REQ-009 idle_or_sync_n, pid_n, dev_address_n, end_point_address_n, crc5_n, frame_number_n, data_crc_eop_n, eop_n  output  1 each  phase flags delayed one cycle, aligned with rx_data_out.
REQ-010 error_n  output  1  delayed error input OR sticky bit-stuff error.

Function
REQ-011 prev_bit register SHALL hold the previous rx_data_in sample; it loads 1 (J/idle) whenever start_rxd=0.
REQ-012 With start_rxd=1, each cycle: decoded = 1 if rx_data_in == prev_bit (no transition), 0 if different; prev_bit <= rx_data_in.
REQ-013 rx_data_out SHALL register the decoded bit; latency one gclk from rx_data_in sampled to rx_data_out.
REQ-014 ones_cnt (3 bits) SHALL count consecutive decoded 1s; cleared by a decoded 0, start_rxd=0, or eop=1; saturates at 6.
REQ-015 When ones_cnt==6, the next decoded bit is a stuffed bit: rx_data_valid=0 that cycle, rx_data_out holds its prior value, ones_cnt clears.
REQ-016 If the stuffed-bit position decodes as 1 (no transition), stuff_err SHALL set and stay set until start_rxd=0 or reset.
REQ-017 rx_data_valid=1 for every non-stuffed decoded bit while start_rxd=1; 0 whenever start_rxd=0.
REQ-018 Each phase flag output X_n SHALL equal input X registered one cycle, regardless of start_rxd.
REQ-019 error_n SHALL equal registered (error | stuff_err).
REQ-020 When start_rxd=0: rx_data_out holds last value, rx_data_valid=0, ones_cnt=0, stuff_err=0, prev_bit=1.
REQ-021 start_rxd rising: first sample compares against prev_bit=1; a 0 on the line decodes as 0.
REQ-022 start_rxd=0 and eop=1 on same cycle: both clear ones_cnt; no conflict.

Reset
REQ-023 reset_l=0 SHALL immediately force: rx_data_out=0, rx_data_valid=0, all X_n=0, error_n=0, prev_bit=1, ones_cnt=0, stuff_err=0.
REQ-024 Reset mid-packet discards all decode state; after release decoding restarts as from start_rxd rising (prev_bit=1).
REQ-025 No output SHALL change on gclk while reset_l=0.

Verification
REQ-026 Reset, start_rxd=1, rx_data_in=0 -> next cycle rx_data_out=0, rx_data_valid=1; hold 0 five cycles -> rx_data_out=1 each.
REQ-027 Line 0->1 then hold 5 cycles -> one rx_data_out=0 at transition, then 1s; line 1->0 -> single 0.
REQ-028 Six no-transition cycles then a transition -> six 1s valid, seventh cycle rx_data_valid=0, stuff_err stays 0.
REQ-029 Six no-transition cycles then another no-transition -> rx_data_valid=0, error_n=1 next cycle and sticky until start_rxd=0.
REQ-030 reset_l pulsed low 10 time units mid-stream -> all outputs 0 asynchronously; after release, alternating line for 20 cycles -> rx_data_out=0, rx_data_valid=1 every cycle.
REQ-031 Drive pid=1 one cycle -> pid_n=1 exactly one cycle later, all other X_n=0.

Source files
------------

// File: rtl/nrzi_decode_ap.sv
// nrzi_decode_ap: NRZI line decoder with bit-unstuffing, stuff-error detection and phase-flag alignment
module nrzi_decode_ap (
  input  logic gclk,
  input  logic reset_l,
  input  logic start_rxd,
  input  logic rx_data_in,
  input  logic idle_or_sync,
  input  logic pid,
  input  logic dev_address,
  input  logic end_point_address,
  input  logic crc5,
  input  logic frame_number,
  input  logic data_crc_eop,
  input  logic eop,
  input  logic error,
  output logic rx_data_out,
  output logic rx_data_valid,
  output logic idle_or_sync_n,
  output logic pid_n,
  output logic dev_address_n,
  output logic end_point_address_n,
  output logic crc5_n,
  output logic frame_number_n,
  output logic data_crc_eop_n,
  output logic eop_n,
  output logic error_n
);
  logic       prev_bit, stuff_err, decoded, stuffed, stuff_err_nxt;
  logic [2:0] ones_cnt, ones_nxt;
  always_comb begin
    decoded       = rx_data_in == prev_bit;
    stuffed       = ones_cnt == 3'd6;
    stuff_err_nxt = start_rxd & (stuff_err | (stuffed & decoded));
    ones_nxt      = (!start_rxd || eop || stuffed || !decoded) ? 3'd0 : ones_cnt + 3'd1;
  end
  // error_n uses the next stuff_err so the error lines up with the dropped stuffed bit
  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      prev_bit            <= 1'b1;
      ones_cnt            <= 3'd0;
      stuff_err           <= 1'b0;
      rx_data_out         <= 1'b0;
      rx_data_valid       <= 1'b0;
      idle_or_sync_n      <= 1'b0;
      pid_n               <= 1'b0;
      dev_address_n       <= 1'b0;
      end_point_address_n <= 1'b0;
      crc5_n              <= 1'b0;
      frame_number_n      <= 1'b0;
      data_crc_eop_n      <= 1'b0;
      eop_n               <= 1'b0;
      error_n             <= 1'b0;
    end else begin
      prev_bit            <= start_rxd ? rx_data_in : 1'b1;
      ones_cnt            <= ones_nxt;
      stuff_err           <= stuff_err_nxt;
      rx_data_valid       <= start_rxd & ~stuffed;
      if (start_rxd && !stuffed) rx_data_out <= decoded;
      idle_or_sync_n      <= idle_or_sync;
      pid_n               <= pid;
      dev_address_n       <= dev_address;
      end_point_address_n <= end_point_address;
      crc5_n              <= crc5;
      frame_number_n      <= frame_number;
      data_crc_eop_n      <= data_crc_eop;
      eop_n               <= eop;
      error_n             <= error | stuff_err_nxt;
    end
  end
endmodule

// File: tb/tb_nrzi_decode_ap.sv
// tb_nrzi_decode_ap: directed-vector self-checking bench for nrzi_decode_ap
module tb_nrzi_decode_ap;
  logic gclk = 0, reset_l = 1, start_rxd = 0, rx_data_in = 1;
  logic [8:0] fl = '0;
  logic rx_data_out, rx_data_valid, idle_or_sync_n, pid_n, dev_address_n, end_point_address_n;
  logic crc5_n, frame_number_n, data_crc_eop_n, eop_n, error_n;
  logic [8:0] fl_n;
  int n_cmp = 0, n_err = 0;
  assign fl_n = {idle_or_sync_n, pid_n, dev_address_n, end_point_address_n, crc5_n,
                 frame_number_n, data_crc_eop_n, eop_n, error_n};
  always #5 gclk = ~gclk;
  nrzi_decode_ap dut (
    .gclk(gclk), .reset_l(reset_l), .start_rxd(start_rxd), .rx_data_in(rx_data_in),
    .idle_or_sync(fl[8]), .pid(fl[7]), .dev_address(fl[6]), .end_point_address(fl[5]),
    .crc5(fl[4]), .frame_number(fl[3]), .data_crc_eop(fl[2]), .eop(fl[1]), .error(fl[0]),
    .rx_data_out(rx_data_out), .rx_data_valid(rx_data_valid),
    .idle_or_sync_n(idle_or_sync_n), .pid_n(pid_n), .dev_address_n(dev_address_n),
    .end_point_address_n(end_point_address_n), .crc5_n(crc5_n), .frame_number_n(frame_number_n),
    .data_crc_eop_n(data_crc_eop_n), .eop_n(eop_n), .error_n(error_n)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input logic d);
    rx_data_in = d;
    @(posedge gclk);
    #1;
  endtask
  task automatic out_is(input string tag, input logic d, input logic v, input logic e);
    check({tag, ".data"}, rx_data_out, d);
    check({tag, ".valid"}, rx_data_valid, v);
    check({tag, ".err"}, error_n, e);
  endtask
  initial begin
    #1 reset_l = 0;
    #2 check("rst_outs", {rx_data_out, rx_data_valid, fl_n}, 0);
    fl = '1; start_rxd = 1;
    tick(0); tick(1);
    check("rst_hold", {rx_data_out, rx_data_valid, fl_n}, 0);
    fl = '0; start_rxd = 0;
    reset_l = 1;
    tick(1);
    // decode after reset: first 0 is a transition, then held 0s decode as 1
    start_rxd = 1;
    tick(0); out_is("first0", 0, 1, 0);
    for (int i = 0; i < 5; i++) begin tick(0); out_is("hold0", 1, 1, 0); end
    start_rxd = 0; tick(1); out_is("idle_hold", 1, 0, 0);
    start_rxd = 1;
    tick(0); out_is("tr_a", 0, 1, 0);
    tick(1); out_is("tr_01", 0, 1, 0);
    for (int i = 0; i < 5; i++) begin tick(1); out_is("hold1", 1, 1, 0); end
    tick(0); out_is("tr_10", 0, 1, 0);
    // legal stuffed bit
    start_rxd = 0; tick(1); start_rxd = 1;
    for (int i = 0; i < 6; i++) begin tick(1); out_is("six1", 1, 1, 0); end
    tick(0); out_is("stuff_ok", 1, 0, 0);
    tick(0); out_is("after_stuff", 1, 1, 0);
    // stuff violation is sticky until start_rxd drops
    start_rxd = 0; tick(1); start_rxd = 1;
    for (int i = 0; i < 6; i++) begin tick(1); out_is("six1b", 1, 1, 0); end
    tick(1); out_is("stuff_bad", 1, 0, 1);
    tick(0); out_is("sticky0", 0, 1, 1);
    tick(0); out_is("sticky1", 1, 1, 1);
    start_rxd = 0; tick(1); out_is("err_clr", 1, 0, 0);
    // eop clears the ones counter
    start_rxd = 1;
    for (int i = 0; i < 5; i++) tick(1);
    fl[1] = 1; tick(1); fl[1] = 0;
    check("eop_n", eop_n, 1);
    tick(1); out_is("eop_clr", 1, 1, 0);
    check("eop_n_drop", eop_n, 0);
    // asynchronous reset mid-stream, then alternating line
    fl[7] = 1; tick(0); fl[7] = 0;
    check("pid_pre", pid_n, 1);
    reset_l = 0;
    #2 check("mid_rst", {rx_data_out, rx_data_valid, fl_n}, 0);
    #8 reset_l = 1;
    for (int i = 0; i < 20; i++) begin tick(i[0] ? 1'b1 : 1'b0); out_is("alt", 0, 1, 0); end
    // each phase flag delayed exactly one cycle, independently of start_rxd
    start_rxd = 0;
    for (int i = 0; i < 9; i++) begin
      fl = 9'd1 << i; tick(1);
      check("flag_n", fl_n, 9'd1 << i);
    end
    fl = '0; tick(1); check("flags_off", fl_n, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
